// File: rtl/sc_road_shifter_if.sv
// rtl/sc_road_shifter_if.sv - controller strobes and road-row datapath results
interface sc_road_shifter_if #(
    parameter int ROWS       = 4,
    parameter int COUNTWIDTH = 4
);
    logic                   SC_ROADSHIFTER_clear_InLow;
    logic                   SC_ROADSHIFTER_load_InLow;
    logic                   SC_ROADSHIFTER_upcount_InLow;
    logic                   SC_ROADSHIFTER_T0_OutLow;
    logic [8*ROWS-1:0]      SC_ROADSHIFTER_rows_Out;
    logic [COUNTWIDTH-1:0]  SC_ROADSHIFTER_count_Out;
    logic [15:0]            SC_ROADSHIFTER_shifts_Out;

    modport master (
        output SC_ROADSHIFTER_clear_InLow,
        output SC_ROADSHIFTER_load_InLow,
        output SC_ROADSHIFTER_upcount_InLow,
        input  SC_ROADSHIFTER_T0_OutLow,
        input  SC_ROADSHIFTER_rows_Out,
        input  SC_ROADSHIFTER_count_Out,
        input  SC_ROADSHIFTER_shifts_Out
    );

    modport slave (
        input  SC_ROADSHIFTER_clear_InLow,
        input  SC_ROADSHIFTER_load_InLow,
        input  SC_ROADSHIFTER_upcount_InLow,
        output SC_ROADSHIFTER_T0_OutLow,
        output SC_ROADSHIFTER_rows_Out,
        output SC_ROADSHIFTER_count_Out,
        output SC_ROADSHIFTER_shifts_Out
    );
endinterface

// File: rtl/sc_road_shifter.sv
// rtl/sc_road_shifter.sv - tick prescaler, LFSR road generator and shifting row buffer
module sc_road_shifter #(
    parameter int         ROWS       = 4,
    parameter int         COUNTWIDTH = 4,
    parameter int         TICK_LIMIT = 10,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic             SC_ROADSHIFTER_CLOCK_50,
    input  logic             SC_ROADSHIFTER_RESET_InHigh,
    sc_road_shifter_if.slave bus
);
    // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
    localparam logic [7:0]            SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [COUNTWIDTH-1:0] LIMIT    = COUNTWIDTH'(TICK_LIMIT);

    logic [8*ROWS-1:0]     rowReg;
    logic [COUNTWIDTH-1:0] countReg;
    logic [7:0]            lfsrReg;
    logic [7:0]            lfsrNext;
    logic [15:0]           shiftsReg;
    logic                  clearAll;

    assign clearAll = SC_ROADSHIFTER_RESET_InHigh || !bus.SC_ROADSHIFTER_clear_InLow;

    always_comb begin
        lfsrNext = {lfsrReg[6:0], lfsrReg[7] ^ lfsrReg[5] ^ lfsrReg[4] ^ lfsrReg[3]};
        if (lfsrReg == 8'h00) begin
            lfsrNext = SEED_EFF;
        end
    end

    always_ff @(posedge SC_ROADSHIFTER_CLOCK_50) begin
        if (clearAll) begin
            countReg  <= '0;
            rowReg    <= '0;
            lfsrReg   <= SEED_EFF;
            shiftsReg <= '0;
        end else if (!bus.SC_ROADSHIFTER_load_InLow) begin
            // Newest row enters at the bottom byte; the top byte falls off.
            rowReg   <= {rowReg[8*ROWS-9:0], lfsrReg};
            lfsrReg  <= lfsrNext;
            countReg <= '0;
            if (shiftsReg != 16'hFFFF) begin
                shiftsReg <= shiftsReg + 16'd1;
            end
        end else if (!bus.SC_ROADSHIFTER_upcount_InLow) begin
            if (countReg < LIMIT) begin
                countReg <= countReg + COUNTWIDTH'(1);
            end
        end
    end

    assign bus.SC_ROADSHIFTER_T0_OutLow  = (countReg != LIMIT);
    assign bus.SC_ROADSHIFTER_rows_Out   = rowReg;
    assign bus.SC_ROADSHIFTER_count_Out  = countReg;
    assign bus.SC_ROADSHIFTER_shifts_Out = shiftsReg;
endmodule
